// File: rtl/montgomery_modexp_pkg.sv
// Shared types and width helpers for the Montgomery modular exponentiator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mont_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SQ_P  = 3'd1,
        ST_SQ_R  = 3'd2,
        ST_MUL_P = 3'd3,
        ST_MUL_R = 3'd4,
        ST_DONE  = 3'd5
    } modexp_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_EXP_WIDTH  = 8;

    // Full product of two DATA_WIDTH operands, kept untruncated for the reduction.
    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

    // Bit-index register width; a one-bit exponent still needs a one-bit index.
    function automatic int idx_width(input int ew);
        return (ew > 1) ? $clog2(ew) : 1;
    endfunction

endpackage

// File: rtl/montgomery_modexp_reduce.sv
// Montgomery reduction: result = t * R^-1 mod n, R = 2^DATA_WIDTH, for t < n*R.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module montgomery_reduce
    import mont_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [prod_width(DATA_WIDTH)-1:0] t,
    input  logic [DATA_WIDTH-1:0]             modulant,
    input  logic [DATA_WIDTH-1:0]             R_minus_one,
    output logic [DATA_WIDTH-1:0]             result
);
    localparam int W     = DATA_WIDTH;
    localparam int PW    = prod_width(DATA_WIDTH);
    // Newton doubles correct bits from 3 (odd n is its own inverse mod 8).
    localparam int ITERS = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  inv;
    logic [W-1:0]  n_prime;
    logic [W-1:0]  m;
    logic [PW-1:0] mn;
    logic          carry;
    logic [W:0]    u;
    logic [W:0]    diff;

    // REDC: pick m so t + m*n is divisible by R, shift, then one conditional subtract.
    always_comb begin
        inv = modulant;
        for (int i = 0; i < ITERS; i++) begin
            inv = inv * (W'(2) - modulant * inv);
        end
        n_prime = (~inv + W'(1)) & R_minus_one;
        m       = (t[W-1:0] * n_prime) & R_minus_one;
        mn      = PW'(m) * PW'(modulant);
        // Low halves sum to exactly 0 or R; a carry exists iff they are nonzero.
        carry   = |mn[W-1:0];
        u       = {1'b0, t[PW-1:W]} + {1'b0, mn[PW-1:W]} + (W+1)'(carry);
        diff    = u - {1'b0, modulant};
        result  = (u >= {1'b0, modulant}) ? diff[W-1:0] : u[W-1:0];
    end

endmodule

// File: rtl/montgomery_modexp.sv
// Square-and-multiply base^exp mod n in the Montgomery domain, MSB-first exponent scan.
// Latency: done 2*(EXP_WIDTH + popcount(exp)) cycles after the accepting edge.
// Backpressure: start honoured only in IDLE; ignored (not queued) while busy or done.
module montgomery_modexp
    import mont_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base_m,
    input  logic [DATA_WIDTH-1:0] one_m,
    input  logic [EXP_WIDTH-1:0]  exp,
    input  logic [DATA_WIDTH-1:0] modulant,
    input  logic [DATA_WIDTH-1:0] R_minus_one,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = prod_width(DATA_WIDTH);
    localparam int IW = idx_width(EXP_WIDTH);

    modexp_state_t  state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   base_q, base_d;
    logic [W-1:0]   mod_q, mod_d;
    logic [W-1:0]   rm1_q, rm1_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [PW-1:0]  t_q, t_d;
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   red;

    // Single shared reducer; its output is only captured in the *_R states.
    montgomery_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_reduce (
        .t           (t_q),
        .modulant    (mod_q),
        .R_minus_one (rm1_q),
        .result      (red)
    );

    // Next-state and datapath: product phase then reduce phase per modular multiply.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        mod_d    = mod_q;
        rm1_d    = rm1_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        t_d      = t_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_m;
                    exp_d   = exp;
                    mod_d   = modulant;
                    rm1_d   = R_minus_one;
                    acc_d   = one_m;
                    idx_d   = IW'(EXP_WIDTH - 1);
                    state_d = ST_SQ_P;
                end
            end
            ST_SQ_P: begin
                t_d     = PW'(acc_q) * PW'(acc_q);
                state_d = ST_SQ_R;
            end
            ST_SQ_R: begin
                acc_d = red;
                if (exp_q[idx_q]) begin
                    state_d = ST_MUL_P;
                end else if (idx_q == '0) begin
                    result_d = red;
                    state_d  = ST_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = ST_SQ_P;
                end
            end
            ST_MUL_P: begin
                t_d     = PW'(acc_q) * PW'(base_q);
                state_d = ST_MUL_R;
            end
            ST_MUL_R: begin
                acc_d = red;
                if (idx_q == '0) begin
                    result_d = red;
                    state_d  = ST_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = ST_SQ_P;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and operand registers; reset abandons any computation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            base_q   <= '0;
            mod_q    <= '0;
            rm1_q    <= '0;
            exp_q    <= '0;
            idx_q    <= '0;
            t_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            mod_q    <= mod_d;
            rm1_q    <= rm1_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
            t_q      <= t_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_SQ_P) || (state_q == ST_SQ_R) ||
                    (state_q == ST_MUL_P) || (state_q == ST_MUL_R);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_montgomery_modexp.sv
// Scoreboard bench for montgomery_modexp: result values, done latency, busy/done shape.
// Latency: checks done at 2*(EXP_WIDTH + popcount(exp)) edges after acceptance.
// Backpressure: verifies starts outside IDLE are dropped.
module tb_montgomery_modexp;
    localparam int W = 8;
    localparam int E = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] base_m, one_m, modulant, rm1, result;
    logic [E-1:0] exp_s;
    logic         busy, done;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_res;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    montgomery_modexp #(.DATA_WIDTH(W), .EXP_WIDTH(E)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_m      (base_m),
        .one_m       (one_m),
        .exp         (exp_s),
        .modulant    (modulant),
        .R_minus_one (rm1),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    // Plain-integer reference: (b^e mod n) * R mod n.
    function automatic logic [W-1:0] model(input int n, input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return W'((r * 256) % n);
    endfunction

    task automatic set_ops(input int n, input int onem, input int basem, input int e);
        modulant = W'(n);
        one_m    = W'(onem);
        base_m   = W'(basem);
        exp_s    = E'(e);
        rm1      = 8'hFF;
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns #1 after the accepting edge.
    task automatic launch(input logic [W-1:0] res, input int e);
        exp_t x;
        x.res = res;
        x.lat = 2 * (E + $countones(E'(e)));
        sb.push_back(x);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns #1 after the edge that entered DONE (or after the timeout).
    task automatic wait_done(input string name, input bit inject, input logic [W-1:0] prev);
        int   cyc;
        bit   seen, busy_bad, hold_bad;
        exp_t x;
        cyc = 0; seen = 0; busy_bad = 0; hold_bad = 0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (inject) begin
                start = (cyc == 5 || cyc == 19);
                if (start) exp_s = 8'd1;
            end
            if (done === 1'b1) seen = 1;
            else begin
                if (busy !== 1'b1) busy_bad = 1;
                if (result !== prev) hold_bad = 1;
            end
        end
        x = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
            return;
        end
        checks++;
        if (cyc != x.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, x.lat);
        end
        checks++;
        if (result !== x.res) begin
            errors++;
            $display("FAIL %s result: got %0d, want %0d", name, result, x.res);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
        end
        checks++;
        if (busy_bad || hold_bad) begin
            errors++;
            $display("FAIL %s during_run: busy_drop=%0d result_changed=%0d, want 0 0", name, busy_bad, hold_bad);
        end
        last_res = x.res;
    endtask

    // Full operation plus the one-cycle-done and idle-afterwards checks.
    task automatic do_op(input string name, input int n, input int onem, input int basem,
                         input int e, input logic [W-1:0] res, input bit inject);
        int extra_done;
        set_ops(n, onem, basem, e);
        launch(res, e);
        wait_done(name, inject, last_res);
        start = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || result !== last_res) extra_done++;
        end
        checks++;
        if (extra_done != 0) begin
            errors++;
            $display("FAIL %s after_done: %0d cycles with done/busy/result disturbed, want 0", name, extra_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        set_ops(13, 9, 5, 3);
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%0d, want 0 0 0", busy, done, result);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b result=%0d, want 0 0 0", busy, done, result);
        end
        last_res = 8'd0;
    endtask

    task automatic test_basic();
        do_op("exp3",   13, 9, 5, 3,   8'd7, 1'b0);
        do_op("exp0",   13, 9, 5, 0,   8'd9, 1'b0);
        do_op("exp1",   13, 9, 5, 1,   8'd5, 1'b0);
        do_op("exp12",  13, 9, 5, 12,  8'd9, 1'b0);
        do_op("exp255", 13, 9, 5, 255, 8'd7, 1'b0);
    endtask

    task automatic test_ignored_start();
        do_op("ignored_start", 13, 9, 5, 3, 8'd7, 1'b1);
    endtask

    task automatic test_async_reset();
        int stray;
        set_ops(13, 9, 5, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b result=%0d, want 0 0 0", busy, done, result);
        end
        @(negedge clk); reset = 1'b0;
        last_res = 8'd0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL no_done_after_reset: %0d active cycles, want 0", stray);
        end
        do_op("after_reset", 13, 9, 5, 1, 8'd5, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_ops(13, 9, 5, 1);
        launch(8'd5, 1);
        wait_done("b2b_first", 1'b0, last_res);
        // start held through the DONE cycle: must not be taken until IDLE.
        set_ops(239, 17, 17, 255);
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd5) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b result=%0d, want 0 0 5", busy, done, result);
        end
        launch(8'd17, 255);
        wait_done("b2b_second", 1'b0, 8'd5);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int mods[4] = '{13, 239, 101, 255};
        int n, b, e;
        for (int k = 0; k < 6; k++) begin
            n = mods[$urandom_range(0, 3)];
            b = $urandom_range(0, n - 1);
            e = $urandom_range(0, 255);
            do_op("random", n, 256 % n, (b * 256) % n, e, model(n, b, e), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
